// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN shift-add or restoring shift-subtract
// steps, then one sign-fix cycle and a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | waiting for start; operands conditioned and latched on accept
//   CALC  | one radix-2 multiply or divide step per cycle, XLEN cycles
//   FIX   | sign correction, special-case override, result/flags update
//   DONE  | done pulse; always returns to IDLE
module muldiv_unit #(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int            CW      = $clog2(XLEN);
    localparam logic [CW-1:0] LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_raw;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            neg_q;
    logic            rem_neg_q;
    logic            dz_q;
    logic            ovf_q;

    // operand conditioning for the request presented in IDLE
    logic            rs1_signed, rs2_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            dz_in, ovf_in, special_in;

    assign rs1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign rs2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg      = rs1_signed & operand1[XLEN-1];
    assign b_neg      = rs2_signed & operand2[XLEN-1];
    assign a_mag      = a_neg ? -operand1 : operand1;
    assign b_mag      = b_neg ? -operand2 : operand2;
    assign dz_in      = op[2] && (operand2 == '0);
    assign ovf_in     = ((op == OP_DIV) || (op == OP_REM)) && (operand1 == MIN_NEG) && (operand2 == '1);
    assign special_in = dz_in || ovf_in;

    // one iteration step; hi/lo hold {product} for multiply, {remainder, quotient} for divide
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ok;
    logic [XLEN-1:0] hi_n, lo_n;

    assign mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, mcand}) : {1'b0, hi};
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_ok    = ~div_diff[XLEN];

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (op_q[2]) begin
            hi_n = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ok};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_val;

    assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
    assign quo_s  = neg_q ? -lo : lo;
    assign rem_s  = rem_neg_q ? -hi : hi;

    always_comb begin
        fix_val = '0;
        case (op_q)
            OP_MUL:                         fix_val = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fix_val = dz_q ? '1 : (ovf_q ? a_raw : quo_s);
            OP_REM, OP_REMU:                fix_val = dz_q ? a_raw : (ovf_q ? '0 : rem_s);
            default:                        fix_val = '0;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            a_raw     <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q      <= op;
                        a_raw     <= operand1;
                        hi        <= '0;
                        lo        <= op[2] ? a_mag : b_mag;
                        mcand     <= op[2] ? b_mag : a_mag;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dz_q      <= dz_in;
                        ovf_q     <= ovf_in;
                        cnt       <= '0;
                        state     <= (special_in && (FAST_SPECIAL != 0)) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= hi_n;
                        lo  <= lo_n;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_val;
                        flags  <= {(fix_val == '0), fix_val[XLEN-1], dz_q, ovf_q};
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency, flush and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_s;
    logic [2:0]  op;
    logic [31:0] operand1, operand2;
    logic        flush;
    logic        busy, done, busy_s, done_s;
    logic [31:0] result, result_s;
    logic [3:0]  flags, flags_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2), .flush(flush),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    muldiv_unit #(.XLEN(32), .FAST_SPECIAL(0)) u_slow (
        .clk(clk), .reset(reset), .start(start_s), .op(op),
        .operand1(operand1), .operand2(operand2), .flush(flush),
        .busy(busy_s), .done(done_s), .result(result_s), .flags(flags_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with the selected unit idle.
    task automatic do_op(input bit sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input int elat,
                         input int poke, input bit fid, input string tag);
        int n;
        op = o; operand1 = a; operand2 = b;
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_s = 1'b0;
        chk({tag, ".busy"}, sel ? busy_s : busy, 1);
        n = 0;
        while (!(sel ? done_s : done) && n < 100) begin
            if (n == poke) begin
                if (sel) start_s = 1'b1; else start = 1'b1;
                op = 3'b101; operand1 = 32'd100; operand2 = 32'd3;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0; start_s = 1'b0;
        end
        chk({tag, ".latency"}, n + 1, elat);
        chk({tag, ".result"}, sel ? result_s : result, er);
        chk({tag, ".flags"}, sel ? flags_s : flags, ef);
        if (fid) begin
            flush = 1'b1;
            #1;
            chk({tag, ".done_kept"}, done, 1);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        chk({tag, ".done_low"}, sel ? done_s : done, 0);
        chk({tag, ".busy_low"}, sel ? busy_s : busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_s = 1'b0; flush = 1'b0;
        op = 3'b000; operand1 = '0; operand2 = '0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        chk("rst.flags", flags, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        do_op(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100, 34, -1, 0, "mul");
        do_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 34, -1, 0, "mulhu");
        do_op(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 34, -1, 0, "mulh_m1");
        do_op(0, 3'b001, 32'h80000000, 32'd2,        32'hFFFFFFFF, 4'b0100, 34, -1, 0, "mulh_min");
        do_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 34, -1, 0, "mulhsu");
        do_op(0, 3'b000, 32'd6,        32'd7,        32'd42,       4'b0000, 34,  3, 0, "mul_ignore");
        do_op(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100, 34, -1, 0, "div");
        do_op(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, 34, -1, 0, "rem");
        do_op(0, 3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        4'b0000, 34, -1, 0, "div_nn");
        do_op(0, 3'b101, 32'd100,      32'd7,        32'd14,       4'b0000, 34, -1, 1, "divu");
        do_op(0, 3'b111, 32'd100,      32'd7,        32'd2,        4'b0000, 34, -1, 0, "remu");
        do_op(0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1000, 34, -1, 0, "divu_big");
        do_op(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0110,  2, -1, 0, "divu_dz");
        do_op(0, 3'b111, 32'd5,        32'd0,        32'd5,        4'b0010,  2, -1, 0, "remu_dz");
        do_op(0, 3'b100, 32'hFFFFFFFC, 32'd0,        32'hFFFFFFFF, 4'b0110,  2, -1, 0, "div_dz");
        do_op(0, 3'b110, 32'hFFFFFFFC, 32'd0,        32'hFFFFFFFC, 4'b0110,  2, -1, 0, "rem_dz");
        do_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0101,  2, -1, 0, "div_ovf");
        do_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1001,  2, -1, 0, "rem_ovf");
        do_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 34, -1, 0, "mulhsu2");

        // flush in cycle T+10 of a multiply
        op = 3'b000; operand1 = 32'd3; operand2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.busy", busy, 0);
        chk("flush.done", done, 0);
        chk("flush.result", result, 32'hFFFFFFFF);
        chk("flush.flags", flags, 4'b0100);
        do_op(0, 3'b000, 32'd9, 32'd9, 32'd81, 4'b0000, 34, -1, 0, "after_flush");

        // asynchronous reset in cycle T+5 of a multiply
        op = 3'b000; operand1 = 32'd5; operand2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #3 reset = 1'b1;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.result", result, 0);
        chk("arst.flags", flags, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(0, 3'b000, 32'd3, 32'd4, 32'd12, 4'b0000, 34, -1, 0, "after_rst");

        // FAST_SPECIAL=0: special cases take full latency, same results
        do_op(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0101, 34, -1, 0, "slow_ovf");
        do_op(1, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0110, 34, -1, 0, "slow_dz");
        do_op(1, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, 34, -1, 0, "slow_rem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
